// File: rtl/edge_pkg.sv
// Shared pixel/window types for the edge-detection pipeline (window
// generator and the non-maximum suppression stage that follows it).
package edge_pkg;

    typedef logic [7:0] pixel_t;      // gradient magnitude
    typedef logic [1:0] angle_t;      // quantised gradient direction
    typedef pixel_t [8:0] window_t;   // 3x3 window, [0] top-left .. [8] bottom-right

    // One stored pixel as it travels through the line buffers.
    typedef struct packed {
        angle_t ang;
        pixel_t mag;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

endpackage

// File: rtl/line_buffer.sv
// Enable-controlled shift register one image line deep. The output is the
// entry written DEPTH enables ago, i.e. the pixel directly above the one
// being written. Contents are deliberately not reset: stale data only ever
// lands in window positions that are never emitted.
module line_buffer #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Shift one position per accepted pixel; hold otherwise.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster-order stream of gradient
// magnitude/angle pixels. Two chained line buffers supply the two rows
// above the incoming pixel; a 3x3 register shifts left on each accepted
// pixel. A window is emitted only once it lies fully inside the image.
module window_gen
    import edge_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic    clk,
    input  logic    n_rst,
    input  logic    in_valid,
    input  pixel_t  in_mag,
    input  angle_t  in_angle,
    output logic    in_ready,
    output logic    out_valid,
    output window_t out_mag,
    output angle_t  out_angle,
    output logic    out_last,
    input  logic    out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_valid;
    logic          r_last;
    window_t       r_win;
    angle_t        r_ang_ctr;   // angle of window centre, position [4]
    angle_t        r_ang_mid;   // angle of newest middle-row pixel, position [5]

    logic          w_acc;
    logic          w_col_end;
    logic          w_row_end;
    logic          w_emit;
    logic          w_frame_end;
    pix_t          w_new;
    pix_t          w_up1;       // pixel at (row-1, col)
    pix_t          w_up2;       // pixel at (row-2, col)

    // Output register may be refilled whenever it is empty or being drained.
    assign in_ready    = !r_valid || out_ready;
    assign w_acc       = in_valid && in_ready;
    assign w_col_end   = (r_col == CW'(IMG_W - 1));
    assign w_row_end   = (r_row == RW'(IMG_H - 1));
    assign w_emit      = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_frame_end = w_row_end && w_col_end;
    assign w_new       = {in_angle, in_mag};

    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_acc),
        .i_din  (w_new),
        .o_dout (w_up1)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb2 (
        .clk    (clk),
        .i_en   (w_acc),
        .i_din  (w_up1),
        .o_dout (w_up2)
    );

    // Raster position of the next pixel to accept; wraps straight into the
    // next frame so back-to-back frames need no idle cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Window shifts one column left per accepted pixel; the new right
    // column is {two rows up, one row up, incoming}.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_win     <= '0;
            r_ang_ctr <= '0;
            r_ang_mid <= '0;
        end else if (w_acc) begin
            r_win[0]  <= r_win[1];
            r_win[1]  <= r_win[2];
            r_win[2]  <= w_up2.mag;
            r_win[3]  <= r_win[4];
            r_win[4]  <= r_win[5];
            r_win[5]  <= w_up1.mag;
            r_win[6]  <= r_win[7];
            r_win[7]  <= r_win[8];
            r_win[8]  <= in_mag;
            r_ang_ctr <= r_ang_mid;
            r_ang_mid <= w_up1.ang;
        end
    end

    // Output handshake: load on window-producing acceptance, drop when
    // drained without a replacement, hold while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_acc) begin
            r_valid <= w_emit;
            r_last  <= w_emit && w_frame_end;
        end else if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_mag   = r_win;
    assign out_angle = r_ang_ctr;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x6 image: ramp frames, output stall,
// gapped input, mid-frame reset and back-to-back frames.
module tb_window_gen;
    import edge_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NP = W * H;
    localparam int NW = (W - 2) * (H - 2);

    logic    clk = 1'b0;
    logic    n_rst = 1'b0;
    logic    in_valid = 1'b0;
    pixel_t  in_mag = '0;
    angle_t  in_angle = '0;
    logic    in_ready;
    logic    out_valid;
    window_t out_mag;
    angle_t  out_angle;
    logic    out_last;
    logic    out_ready = 1'b1;

    always #5 clk = ~clk;

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_mag    (in_mag),
        .in_angle  (in_angle),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_mag   (out_mag),
        .out_angle (out_angle),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    typedef struct {
        window_t mag;
        angle_t  ang;
        logic    last;
        int      acc;    // pixels accepted when the window was consumed
    } win_t;

    typedef struct {
        int idx;
        int m[9];
        int ang;
        bit last;
    } vec_t;

    win_t wq[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window k (0..NW-1) of a ramp frame with offset off.
    function automatic window_t model_win(input int k, input int off);
        window_t w;
        int r, c;
        r = k / (W - 2) + 2;
        c = k % (W - 2) + 2;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[dr*3+dc] = pixel_t'((r - 2 + dr) * W + (c - 2 + dc) + off);
        return w;
    endfunction

    function automatic angle_t model_ang(input int k);
        return angle_t'((k % (W - 2) + 1) % 4);
    endfunction

    // Feed npix ramp pixels (frame f offset by 100*f), collect windows.
    task automatic run(input int npix, input bit toggle, input int stall_win, input bit drain);
        int p = 0;
        int stall_cnt = 0;
        int idle = 0;
        int q;
        bit prev_acc = 0;
        int prev_col = 0;
        bit done = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(posedge clk); #1;
            if (p < npix) begin
                q        = p % NP;
                in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
                in_mag   = pixel_t'(q + 100 * (p / NP));
                in_angle = angle_t'((q % W) % 4);
            end else begin
                in_valid = 1'b0;
            end
            if (stall_win > 0 && out_valid && wq.size() == stall_win - 1 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (prev_acc && prev_col < 2) chk("rowwrap_no_valid", out_valid, 1'b0);
            if (!out_ready) begin
                chk("stall_mag_hold", out_mag, model_win(stall_win - 1, 0));
                chk("stall_in_ready", in_ready, 1'b0);
            end
            if (out_valid && out_ready) wq.push_back('{out_mag, out_angle, out_last, p});
            prev_acc = in_valid && in_ready;
            if (prev_acc) begin
                prev_col = (p % NP) % W;
                p++;
            end
            if (p >= npix) begin
                if (!drain) done = 1;
                else if (!out_valid && in_valid == 1'b0) begin
                    idle++;
                    if (idle >= 3) done = 1;
                end
            end
        end
        if (!done) chk("run_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_frames(input string tag, input int nfr);
        int kk;
        chk({tag, "_count"}, wq.size(), NW * nfr);
        for (int k = 0; k < wq.size() && k < NW * nfr; k++) begin
            kk = k % NW;
            chk({tag, "_mag"},  wq[k].mag,  model_win(kk, 100 * (k / NW)));
            chk({tag, "_ang"},  wq[k].ang,  model_ang(kk));
            chk({tag, "_last"}, wq[k].last, (kk == NW - 1));
        end
    endtask

    initial begin
        window_t w;
        int low;
        tbl[0] = '{0,  '{0, 1, 2, 8, 9, 10, 16, 17, 18},            1, 1'b0};
        tbl[1] = '{5,  '{5, 6, 7, 13, 14, 15, 21, 22, 23},          2, 1'b0};
        tbl[2] = '{6,  '{8, 9, 10, 16, 17, 18, 24, 25, 26},         1, 1'b0};
        tbl[3] = '{14, '{18, 19, 20, 26, 27, 28, 34, 35, 36},       3, 1'b0};
        tbl[4] = '{23, '{29, 30, 31, 37, 38, 39, 45, 46, 47},       2, 1'b1};
        tbl[5] = '{24, '{100, 101, 102, 108, 109, 110, 116, 117, 118}, 1, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_out_mag",   out_mag,   '0);
        chk("rst_out_angle", out_angle, '0);
        chk("rst_in_ready",  in_ready,  1'b1);
        @(negedge clk);
        n_rst = 1'b1;

        // Plain ramp frame
        wq.delete();
        run(NP, 1'b0, 0, 1'b1);
        check_frames("ramp", 1);
        if (wq.size() > 0) chk("ramp_first_acc", wq[0].acc, 19);

        // Stall while the third window is presented
        wq.delete();
        run(NP, 1'b0, 3, 1'b1);
        check_frames("stall", 1);

        // Input valid toggling every cycle
        wq.delete();
        run(NP, 1'b1, 0, 1'b1);
        check_frames("gap", 1);

        // Reset after 20 accepted pixels
        wq.delete();
        run(20, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_mag",   out_mag,   '0);
        @(negedge clk);
        n_rst = 1'b1;
        wq.delete();
        run(NP, 1'b0, 0, 1'b1);
        check_frames("postrst", 1);
        if (wq.size() > 0) chk("postrst_first_acc", wq[0].acc, 19);

        // Two back-to-back frames, second offset by 100
        wq.delete();
        run(2 * NP, 1'b0, 0, 1'b1);
        check_frames("twofr", 2);
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].idx < wq.size()) begin
                for (int j = 0; j < 9; j++) w[j] = pixel_t'(tbl[i].m[j]);
                chk("tbl_mag",  wq[tbl[i].idx].mag,  w);
                chk("tbl_ang",  wq[tbl[i].idx].ang,  angle_t'(tbl[i].ang));
                chk("tbl_last", wq[tbl[i].idx].last, tbl[i].last);
            end else begin
                chk("tbl_missing", 1'b0, 1'b1);
            end
        end
        low = 0;
        for (int k = NW; k < wq.size(); k++)
            for (int j = 0; j < 9; j++)
                if (wq[k].mag[j] < 8'd100) low++;
        chk("twofr_no_stale", low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
